temporal_pulse_gen: RTL and testbench
=====================================

// Module: temporal_pulse_gen
// PURPOSE
// - Temporal (unary) encoder: latches one binary word per lane and emits, over a fixed window
//   of 2**WD cycles, exactly value[i] single-cycle pulses on lane i.
// - Transmit end of the temporal-count path; pulse_out[i] drives the per-lane enable of the
//   downstream temporal counter bank, which recovers value[i] after one window.
// PARAMETERS
// - LANES  default `NUM_CNT (`NUM_CNT/`FOLD when `FOLD defined)  number of independent lanes
// - WD     default `INWD                                          value width; window = 2**WD cycles
// PORTS
// - clk        in   1         clock; all state on posedge
// - rst_n      in   1         async active-low reset
// - in_valid   in   1         in_value holds a new word set
// - in_ready   out  1         block accepts a word set this cycle
// - in_value   in   LANES*WD  packed [LANES-1:0][WD-1:0] per-lane values
// - hold       in   1         freeze window: phase stalls, all pulses 0
// - pulse_out  out  LANES     per-lane unary pulse
// - pulse_vld  out  1         a window is running and not held
// - win_last   out  1         final phase (2**WD-1) of the window is being emitted
// BEHAVIOUR
// - Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
// - Reset (any time, including mid-window): state=IDLE, phase=0, latched values=0;
//   pulse_out=0, pulse_vld=0, win_last=0, in_ready=1 once out of reset; partial window dropped.
// - FSM IDLE/RUN:
//   - IDLE -> RUN on in_valid&in_ready: latch in_value, phase<=0.
//   - In RUN with !hold: phase<=phase+1.
//   - At phase==2**WD-1 with !hold:
//     - in_valid=1: reload in_value, phase<=0, stay RUN (back-to-back, zero bubble).
//     - else -> IDLE.
//   - hold in RUN: phase, state and values frozen.
// - in_ready = (state==IDLE) | (state==RUN & phase==2**WD-1 & !hold).
//   - in_valid when !in_ready: ignored; the source keeps it asserted.
// - Outputs, combinational from registers and hold; no other input-to-output path:
//   - pulse_vld = (state==RUN) & !hold.
//   - pulse_out[i] = pulse_vld & (cmp(phase) < val[i]); unsigned WD-bit compare.
//   - win_last = pulse_vld & (phase==2**WD-1).
// - Latency: word accepted at edge k; phase-0 pulses visible in cycle after k; the window
//   ends at edge k+2**WD (plus held cycles).
// - Range: val=0 gives no pulses; val=2**WD-1 gives 2**WD-1 pulses (phase 2**WD-1 never
//   pulses), so a WD-bit receiver counter never overflows within one window.
// - Phase counter is WD bits and wraps 2**WD-1 -> 0 only through the reload/IDLE rule above.
// CONFIGURATION
// - TGEN_BITREV_EN defined: cmp(phase) = bit-reverse(phase).
//   - Pulses are spread across the window; the count per window stays exactly val[i].
// - Not defined: cmp(phase) = phase.
//   - Thermometer code: pulses occupy phases 0..val[i]-1 contiguously.
// - Ports, FSM, handshake and latency are identical in both builds.
// STRUCTURE
// - Package tgen_pkg:
//   - state enum tgen_state_e {IDLE, RUN}
//   - typedef lane_val_t = logic [WD-1:0]
//   - localparam PHASE_MAX = 2**WD-1
// - Sub-module tgen_phase_ctr: WD-bit phase counter with hold, clear and last-flag.
//   - It holds the TGEN_BITREV_EN mapping and outputs cmp(phase).
//   - Top keeps the FSM, value registers and per-lane comparators (generate loop over LANES).
// TESTING (directed, WD=4, LANES=4; pulses counted per lane per window)
// - Reset release: in_ready=1, pulse_out=0, pulse_vld=0, win_last=0 in the first cycle.
// - Load {0,1,5,15}: counts {0,1,5,15} after 16 cycles; win_last high only in the 16th cycle.
//   - Without the macro, lane2 pulses at phases 0-4.
//   - With TGEN_BITREV_EN, lane2 pulses at phases 0,2,4,8,12.
// - Back-to-back {3,3,3,3} then {7,0,7,0} with in_valid held high:
//   - in_ready high only in the last phase cycle; 32 contiguous pulse_vld cycles; counts {3..},{7,0,7,0}.
// - hold high for 5 cycles at phase 6:
//   - pulse_out=0 while held; window stretches to 21 cycles; counts still equal the values.
// - in_valid while RUN at phase 9: not accepted and the value is unchanged.
//   - The word is accepted at phase 15 only if still valid.
// - rst_n low at phase 10: outputs 0 immediately (async); after release the block is IDLE,
//   in_ready=1, and a new load yields exact counts.

Source files
------------

// File: rtl/tgen_pkg.sv
// -----------------------------------------------------------------------------
// tgen_pkg -- shared types and defaults for the temporal pulse generator.
//
// Build defaults:
//   INWD     value width (default 4 when not supplied by the build)
//   NUM_CNT  number of counter lanes (default 4 when not supplied by the build)
//   FOLD     lane folding factor; the lane count is NUM_CNT/FOLD (default 1)
// Optional feature macro TGEN_BITREV_EN is consumed by tgen_phase_ctr.
// -----------------------------------------------------------------------------
`ifndef INWD
  `define INWD 4
`endif
`ifndef NUM_CNT
  `define NUM_CNT 4
`endif
`ifndef FOLD
  `define FOLD 1
`endif

package tgen_pkg;

  localparam int DEF_WD    = `INWD;
  localparam int DEF_LANES = `NUM_CNT / `FOLD;

  // Last phase of a window for the default width.
  localparam int PHASE_MAX = 2**DEF_WD - 1;

  typedef logic [DEF_WD-1:0] lane_val_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tgen_state_e;

endpackage

// File: rtl/tgen_phase_ctr.sv
// -----------------------------------------------------------------------------
// tgen_phase_ctr -- WD-bit window phase counter.
//
// Macro: TGEN_BITREV_EN -- when defined, cmp_phase is the bit-reversed phase,
//        which spreads each lane's pulses across the window; otherwise
//        cmp_phase equals phase (thermometer-style pulses).
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clear        load phase with 0 at the next edge (wins over adv)
//   adv          advance phase by one at the next edge
//   phase        current phase
//   cmp_phase    value each lane compares against
//   last         phase is at its final value 2**WD-1
// -----------------------------------------------------------------------------
module tgen_phase_ctr #(
  parameter int WD = tgen_pkg::DEF_WD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          adv,
  output logic [WD-1:0] phase,
  output logic [WD-1:0] cmp_phase,
  output logic          last
);

  localparam logic [WD-1:0] PHASE_LAST = '1;

  logic [WD-1:0] phase_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (adv) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  always_comb begin
    cmp_phase = phase_q;
`ifdef TGEN_BITREV_EN
    for (int b = 0; b < WD; b++) begin
      cmp_phase[b] = phase_q[WD-1-b];
    end
`endif
  end

  assign phase = phase_q;
  assign last  = (phase_q == PHASE_LAST);

endmodule

// File: rtl/temporal_pulse_gen.sv
// -----------------------------------------------------------------------------
// temporal_pulse_gen -- temporal (unary) encoder.
//
// Latches one WD-bit value per lane and, over a window of 2**WD cycles, emits
// exactly value[i] single-cycle pulses on pulse_out[i]. A new word set may be
// accepted in the last phase of a window, giving back-to-back windows.
//
// Macro: TGEN_BITREV_EN (see tgen_phase_ctr) selects bit-reversed pulse
//        placement; ports, handshake and latency are the same either way.
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   in_valid     in_value carries a new word set
//   in_ready     a word set is accepted this cycle when in_valid is high
//   in_value     packed per-lane values [LANES-1:0][WD-1:0]
//   hold         freeze the window (phase stalls, no pulses)
//   pulse_out    per-lane unary pulse
//   pulse_vld    a window is running and not held
//   win_last     final phase of the window is being emitted
// -----------------------------------------------------------------------------
module temporal_pulse_gen
  import tgen_pkg::*;
#(
  parameter int LANES = tgen_pkg::DEF_LANES,
  parameter int WD    = tgen_pkg::DEF_WD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0][WD-1:0]  in_value,
  input  logic                      hold,
  output logic [LANES-1:0]          pulse_out,
  output logic                      pulse_vld,
  output logic                      win_last
);

  tgen_state_e              state_q, state_d;
  logic [LANES-1:0][WD-1:0] val_q;
  logic [WD-1:0]            phase;
  logic [WD-1:0]            cmp_phase;
  logic                     last;
  logic                     run;
  logic                     end_win;
  logic                     accept;

  assign run     = (state_q == RUN);
  // Final, un-held phase: the window completes at the coming edge.
  assign end_win = run & last & ~hold;
  assign in_ready = ~run | end_win;
  assign accept   = in_valid & in_ready;

  tgen_phase_ctr #(
    .WD (WD)
  ) u_phase_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept | end_win),
    .adv       (run & ~hold),
    .phase     (phase),
    .cmp_phase (cmp_phase),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (end_win)   state_d = in_valid ? RUN : IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: the value bank is reset as well: a reset mid-window must drop the
  // old word, and the outputs depend on it through the comparators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else if (accept) begin
      val_q <= in_value;
    end
  end

  assign pulse_vld = run & ~hold;
  assign win_last  = pulse_vld & last;

  // Phase 2**WD-1 never satisfies cmp < val for a WD-bit val in the
  // thermometer build, so at most 2**WD-1 pulses occur per window.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pulse_out[i] = pulse_vld & (cmp_phase < val_q[i]);
  end

  // The absolute phase is only needed inside the counter.
  logic unused_phase;
  assign unused_phase = ^phase;

endmodule

// File: tb/tb_temporal_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_temporal_pulse_gen -- scoreboard bench for temporal_pulse_gen (WD=4,
// LANES=4). The driver pushes every offered word set into a queue; a monitor
// keeps a window-level reference (which beat of the window is running, and
// which word set it carries), pops the queue when a word set is due to be
// taken, and compares handshake, per-beat pulses and per-window counts.
// -----------------------------------------------------------------------------
module tb_temporal_pulse_gen;

  localparam int LANES = 4;
  localparam int WD    = 4;
  localparam int WIN   = 2**WD;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0][WD-1:0] in_value;
  logic                     hold;
  logic [LANES-1:0]         pulse_out;
  logic                     pulse_vld;
  logic                     win_last;

  int checks   = 0;
  int failures = 0;

  logic [LANES*WD-1:0] sb_q[$];
  bit  busy = 1'b0;
  int  beat = 0;
  int  cur_val[LANES];
  int  cnt[LANES];
  bit  rand_hold = 1'b0;

  temporal_pulse_gen #(
    .LANES (LANES),
    .WD    (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .hold      (hold),
    .pulse_out (pulse_out),
    .pulse_vld (pulse_vld),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  // Value a lane's count is compared against during beat p of a window.
  function automatic int order_of(input int p);
`ifdef TGEN_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < WD; b++) begin
      if (((p >> b) & 1) != 0) r += (1 << (WD - 1 - b));
    end
    return r;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    int expv;
    bit exp_vld;
    bit exp_ready;
    logic [LANES*WD-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        beat = 0;
        sb_q.delete();
        check("rst_pulse_vld", int'(pulse_vld), 0);
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_win_last",  int'(win_last),  0);
      end else begin
        exp_vld   = busy && !hold;
        exp_ready = !busy || (beat == WIN - 1 && !hold);
        check("in_ready",  int'(in_ready),  int'(exp_ready));
        check("pulse_vld", int'(pulse_vld), int'(exp_vld));
        check("win_last",  int'(win_last),  int'(exp_vld && beat == WIN - 1));
        expv = 0;
        if (exp_vld) begin
          for (int i = 0; i < LANES; i++) begin
            if (order_of(beat) < cur_val[i]) expv |= (1 << i);
          end
        end
        check("pulse_out", int'(pulse_out), expv);
        for (int i = 0; i < LANES; i++) cnt[i] += int'(pulse_out[i]);

        if (busy && !hold) begin
          if (beat == WIN - 1) begin
            for (int i = 0; i < LANES; i++) begin
              check($sformatf("count_lane%0d", i), cnt[i], cur_val[i]);
            end
            busy = 1'b0;
            beat = 0;
          end else begin
            beat++;
          end
        end

        if (in_valid && exp_ready) begin
          if (sb_q.size() == 0) begin
            check("offer_queue_nonempty", 0, 1);
          end else begin
            w = sb_q.pop_front();
            for (int i = 0; i < LANES; i++) begin
              cur_val[i] = int'(w[i*WD +: WD]);
              cnt[i]     = 0;
            end
            busy = 1'b1;
            beat = 0;
          end
        end
      end
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_hold) hold = ($urandom_range(0, 5) == 0);
  endtask

  // Offer a word set and keep it on in_value until it is taken; in_valid is
  // left high so the caller can chain another word set with no bubble.
  task automatic send(input logic [LANES*WD-1:0] w);
    bit acc;
    int n;
    sb_q.push_back(w);
    in_value = w;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      check("send_accept_timeout", 0, 1);
      in_valid = 1'b0;
      void'(sb_q.pop_back());
    end
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    in_value = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // Lanes {0,1,5,15}, one isolated window.
    send(16'hF510);
    in_valid = 1'b0;
    repeat (20) tick();

    // Back-to-back {3,3,3,3} then {7,0,7,0} with in_valid held high.
    send(16'h3333);
    send(16'h0707);
    in_valid = 1'b0;
    repeat (20) tick();

    // New word offered at phase 9; it may only be taken at phase 15.
    send(16'h2468);
    in_valid = 1'b0;
    repeat (9) tick();
    send(16'hF00F);
    in_valid = 1'b0;
    repeat (20) tick();

    // Hold for 5 cycles starting at phase 6.
    send(16'h9A4C);
    in_valid = 1'b0;
    repeat (6) tick();
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    repeat (20) tick();

    // Asynchronous reset at phase 10, then a fresh window.
    send(16'hBEEF);
    in_valid = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pulse_vld", int'(pulse_vld), 0);
    check("async_rst_pulse_out", int'(pulse_out), 0);
    check("async_rst_win_last",  int'(win_last),  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send(16'h1F2E);
    in_valid = 1'b0;
    repeat (20) tick();

    // Randomised word sets, gaps, chaining and holds.
    rand_hold = 1'b1;
    for (int k = 0; k < 25; k++) begin
      logic [LANES*WD-1:0] w;
      w = LANES*WD'($urandom);
      if (k % 7 == 3) w = 16'hF0F0;
      send(w);
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 20)) tick();
      end
    end
    in_valid  = 1'b0;
    rand_hold = 1'b0;
    hold      = 1'b0;

    n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain_idle",  int'(busy), 0);
    check("queue_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
